// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - register map, FSM encoding and STATUS layout for irq_arbiter
package irq_pkg;

  localparam logic [1:0] ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int STAT_STATE_LSB  = 0;
  localparam int STAT_REQ_BIT    = 2;
  localparam int STAT_ACTIVE_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  // Lowest index wins, so source 0 has the highest priority.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchronizer plus rising-edge detector for one line
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - fixed-priority interrupt arbiter with req/ack/eoi handshake
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC    = 8,
  parameter int SRC_ID_W = 3
) (
  input  logic                SI_ClkIn,
  input  logic                SI_Reset_N,
  input  logic [N_SRC-1:0]    irq_src,
  input  logic                reg_we,
  input  logic [1:0]          reg_addr,
  input  logic [N_SRC-1:0]    reg_wdata,
  output logic [7:0]          reg_rdata,
  output logic                irq_req,
  output logic [SRC_ID_W-1:0] irq_id,
  input  logic                irq_ack,
  input  logic                irq_eoi,
  output logic                irq_active
);

  logic [N_SRC-1:0] level, rise;
  logic [N_SRC-1:0] enable, edge_sel, pending;
  logic [N_SRC-1:0] clr, pending_nxt;
  logic [7:0]       masked8, status;
  logic             sel_live;
  irq_state_t       state;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (SI_ClkIn),
      .rst_n (SI_Reset_N),
      .src   (irq_src[g]),
      .level (level[g]),
      .rise  (rise[g])
    );
  end

  // A new edge in the same cycle as a clear keeps the bit set.
  always_comb begin
    clr = '0;
    if (reg_we && reg_addr == ADDR_PENDING) clr = reg_wdata;
    if (state == ST_REQ && irq_ack) clr[irq_id] = 1'b1;
    pending_nxt = (edge_sel & ((pending & ~clr) | rise)) | (~edge_sel & level);
  end

  always_comb begin
    status = '0;
    status[STAT_STATE_LSB +: 2] = state;
    status[STAT_REQ_BIT]        = irq_req;
    status[STAT_ACTIVE_BIT]     = irq_active;
  end

  assign masked8  = 8'(pending & enable);
  assign sel_live = pending[irq_id] & enable[irq_id];

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      enable    <= '0;
      edge_sel  <= '1;
      pending   <= '0;
      reg_rdata <= '0;
    end else begin
      pending <= pending_nxt;
      if (reg_we && reg_addr == ADDR_ENABLE)   enable   <= reg_wdata;
      if (reg_we && reg_addr == ADDR_EDGE_SEL) edge_sel <= reg_wdata;
      case (reg_addr)
        ADDR_ENABLE:   reg_rdata <= 8'(enable);
        ADDR_PENDING:  reg_rdata <= 8'(pending);
        ADDR_EDGE_SEL: reg_rdata <= 8'(edge_sel);
        ADDR_STATUS:   reg_rdata <= status;
        default:       reg_rdata <= '0;
      endcase
    end
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      state      <= ST_IDLE;
      irq_req    <= 1'b0;
      irq_active <= 1'b0;
      irq_id     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|masked8) begin
            irq_id  <= SRC_ID_W'(lowest_set(masked8));
            state   <= ST_REQ;
            irq_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state      <= ST_SERVICE;
            irq_req    <= 1'b0;
            irq_active <= 1'b1;
          end else if (!sel_live) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (irq_eoi) begin
            state      <= ST_IDLE;
            irq_active <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          irq_req    <= 1'b0;
          irq_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - scoreboard bench for irq_arbiter with a behavioural reference model
module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] src = '0;
  logic       we = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       req, active;
  logic [2:0] id;
  logic       ack = 1'b0, eoi = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  irq_arbiter #(.N_SRC(8), .SRC_ID_W(3)) dut (
    .SI_ClkIn   (clk),
    .SI_Reset_N (rst_n),
    .irq_src    (src),
    .reg_we     (we),
    .reg_addr   (addr),
    .reg_wdata  (wdata),
    .reg_rdata  (rdata),
    .irq_req    (req),
    .irq_id     (id),
    .irq_ack    (ack),
    .irq_eoi    (eoi),
    .irq_active (active)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_REQ = 1, M_SERVICE = 2;

  typedef struct {
    int cyc;
    bit req;
    bit act;
    int id;
  } evt_t;

  evt_t     evq[$];
  bit [7:0] rdq[$];

  bit [7:0] m_en = 8'h00, m_es = 8'hFF, m_pend = 8'h00;
  bit [7:0] smp[4] = '{default: 8'h00};
  int       m_state = M_IDLE, m_id = 0;
  bit       m_req = 1'b0, m_act = 1'b0;

  // Reference model: smp[k] is irq_src as seen k edges before the current one.
  always @(posedge clk) begin : model
    bit [7:0] lvl, rise, kill, np, live;
    int       nstate, nid;
    bit       nreq, nact, found;
    cyc++;
    if (!rst_n) begin
      m_en = 8'h00; m_es = 8'hFF; m_pend = 8'h00;
      m_state = M_IDLE; m_id = 0; m_req = 1'b0; m_act = 1'b0;
      for (int k = 0; k < 4; k++) smp[k] = 8'h00;
    end else begin
      for (int k = 3; k > 0; k--) smp[k] = smp[k-1];
      smp[0] = src;
      lvl  = smp[2];
      rise = smp[2] & ~smp[3];
      case (addr)
        2'd0:    rdq.push_back(m_en);
        2'd1:    rdq.push_back(m_pend);
        2'd2:    rdq.push_back(m_es);
        default: rdq.push_back({4'b0, m_act, m_req, 2'(m_state)});
      endcase
      kill = 8'h00;
      if (we && addr == 2'd1) kill = wdata;
      if (m_state == M_REQ && ack) kill[m_id] = 1'b1;
      for (int i = 0; i < 8; i++)
        np[i] = m_es[i] ? ((m_pend[i] && !kill[i]) || rise[i]) : lvl[i];
      nstate = m_state; nid = m_id; nreq = m_req; nact = m_act;
      if (m_state == M_IDLE) begin
        live = m_pend & m_en;
        found = 1'b0;
        for (int i = 0; i < 8; i++)
          if (live[i] && !found) begin nid = i; found = 1'b1; end
        if (found) begin nstate = M_REQ; nreq = 1'b1; end
      end else if (m_state == M_REQ) begin
        if (ack) begin nstate = M_SERVICE; nreq = 1'b0; nact = 1'b1; end
        else if (!(m_pend[m_id] && m_en[m_id])) begin nstate = M_IDLE; nreq = 1'b0; end
      end else if (eoi) begin
        nstate = M_IDLE; nact = 1'b0;
      end
      if (we && addr == 2'd0) m_en = wdata;
      if (we && addr == 2'd2) m_es = wdata;
      m_pend = np;
      if (nreq != m_req || nact != m_act || nid != m_id)
        evq.push_back('{cyc, nreq, nact, nid});
      m_state = nstate; m_id = nid; m_req = nreq; m_act = nact;
    end
  end

  bit p_req = 1'b0, p_act = 1'b0;
  int p_id = 0;

  always @(negedge clk) begin : monitor
    evt_t     ev;
    bit [7:0] er;
    if (!rst_n) begin
      p_req = 1'b0; p_act = 1'b0; p_id = 0;
      rdq.delete();
      evq.delete();
    end else begin
      if (rdq.size() > 0) begin
        er = rdq.pop_front();
        checks++;
        if (rdata !== er) begin
          errors++;
          $display("FAIL rdata cyc=%0d addr=%0d got=%02h exp=%02h", cyc, addr, rdata, er);
        end
      end
      if (req !== p_req || active !== p_act || int'(id) != p_id) begin
        checks++;
        if (evq.size() == 0) begin
          errors++;
          $display("FAIL evt_unexpected cyc=%0d got req=%0b act=%0b id=%0d", cyc, req, active, id);
        end else begin
          ev = evq.pop_front();
          if (ev.cyc != cyc || ev.req !== req || ev.act !== active || ev.id != int'(id)) begin
            errors++;
            $display("FAIL evt cyc=%0d got req=%0b act=%0b id=%0d exp cyc=%0d req=%0b act=%0b id=%0d",
                     cyc, req, active, id, ev.cyc, ev.req, ev.act, ev.id);
          end
        end
        p_req = req; p_act = active; p_id = int'(id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    tick();
    d = rdata;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !req; i++) tick();
    chk("wait_req", req, 1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #1;
    rst_n = 1'b0; src = '0; we = 1'b0; ack = 1'b0; eoi = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] d;

    reset_dut();
    chk("rst_req", req, 0);
    chk("rst_act", active, 0);
    chk("rst_id", id, 0);
    chk("rst_rdata", rdata, 0);
    rd(2'd2, d); chk("rst_edge_sel", d, 8'hFF);
    src = 8'h10; tick(); src = '0;
    repeat (6) tick();
    chk("no_req_while_disabled", req, 0);

    reset_dut(); wr(2'd0, 8'h0F);
    src = 8'h04; tick(); src = '0;
    tick(); tick();
    chk("no_req_before_pend", req, 0);
    rd(2'd1, d);
    chk("pend_0x04", d, 8'h04);
    chk("req_after_pend", req, 1);
    chk("id_2", id, 2);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("active_after_ack", active, 1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("idle_after_eoi", active, 0);

    reset_dut();
    we = 1'b1; addr = 2'd0; wdata = 8'hFF; src = 8'h0A; tick(); we = 1'b0; src = '0;
    wait_req(); chk("first_id1", id, 1);
    ack = 1'b1; tick(); ack = 1'b0; eoi = 1'b1; tick(); eoi = 1'b0;
    wait_req(); chk("second_id3", id, 3);
    ack = 1'b1; tick(); ack = 1'b0;
    rd(2'd1, d); chk("pend_clear_after_acks", d, 8'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;

    reset_dut(); wr(2'd0, 8'hFF);
    src = 8'h20; tick(); src = '0;
    wait_req(); chk("id5", id, 5);
    wr(2'd1, 8'h20); chk("req_hold_w1c_cycle", req, 1);
    tick(); chk("withdraw_req", req, 0);
    rd(2'd3, d); chk("withdraw_status_idle", d, 8'h00);

    reset_dut(); wr(2'd2, 8'hFE); wr(2'd0, 8'h01);
    src = 8'h01;
    wait_req(); chk("lvl_id0", id, 0);
    ack = 1'b1; tick(); ack = 1'b0; eoi = 1'b1; tick(); eoi = 1'b0;
    tick(); chk("lvl_rereq", req, 1);
    wr(2'd1, 8'h01); tick(); chk("lvl_w1c_req", req, 1);
    rd(2'd1, d); chk("lvl_w1c_pend", d, 8'h01);
    src = '0;

    reset_dut(); wr(2'd0, 8'h01);
    src = 8'h01; tick(); src = '0;
    wait_req();
    src = 8'h01; tick(); src = '0; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    rd(2'd1, d); chk("ack_edge_collide_pend", d, 8'h01);
    eoi = 1'b1; tick(); eoi = 1'b0;
    wait_req(); chk("ack_edge_collide_id", id, 0);

    reset_dut(); wr(2'd0, 8'hFF);
    src = 8'h80; tick(); src = '0;
    wait_req(); addr = 2'd3;
    ack = 1'b1; tick(); ack = 1'b0; tick();
    chk("svc_status", rdata, 8'h0A);
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    chk("async_req", req, 0);
    chk("async_act", active, 0);
    chk("async_id", id, 0);
    chk("async_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    rd(2'd0, d); chk("enable_after_rst", d, 8'h00);

    reset_dut();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_in_idle_req", req, 0);
    rd(2'd3, d); chk("ack_in_idle_status", d, 8'h00);
    wr(2'd0, 8'h02);
    src = 8'h02; tick(); src = '0;
    wait_req();
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("eoi_in_req_req", req, 1);
    rd(2'd3, d); chk("eoi_in_req_status", d, 8'h05);
    ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
    chk("ack_eoi_same_cycle", active, 1);
    eoi = 1'b1; tick(); eoi = 1'b0;

    reset_dut();
    wr(2'd0, 8'($urandom));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) reset_dut();
      src   = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      ack   = ($urandom_range(0, 2) == 0);
      eoi   = ($urandom_range(0, 2) == 0);
      addr  = 2'($urandom);
      we    = ($urandom_range(0, 11) == 0);
      wdata = 8'($urandom);
      tick();
    end
    we = 1'b0; ack = 1'b0; eoi = 1'b0; src = '0;
    repeat (4) tick();
    chk("evq_drained", evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter N_SRC, default 8, number of interrupt sources (1..8).
REQ-002 Parameter SRC_ID_W, default 3, width of the source ID.
REQ-003 SI_ClkIn  input  1  sole clock, CPU pipeline clock domain.
REQ-004 SI_Reset_N  input  1  reset; asynchronous, active-low.
REQ-005 irq_src  input  N_SRC  raw asynchronous request lines: pushbuttons, UART RX, timer.
REQ-006 reg_we  input  1  register write strobe.
REQ-007 reg_addr  input  2  register select: 0 ENABLE, 1 PENDING, 2 EDGE_SEL, 3 STATUS.
REQ-008 reg_wdata  input  N_SRC  write data.
REQ-009 reg_rdata  output  8  registered read data, zero-extended.
REQ-010 irq_req  output  1  interrupt request to the CPU.
REQ-011 irq_id  output  SRC_ID_W  ID of the source being requested or serviced.
REQ-012 irq_ack  input  1  CPU has taken the interrupt.
REQ-013 irq_eoi  input  1  CPU has finished its handler.
REQ-014 irq_active  output  1  a handler is in progress.

Function
REQ-015 Each irq_src bit passes a 2-flop synchronizer; a third flop holds the previous synced value for edge detection.
REQ-016 Edge mode (EDGE_SEL[i]=1): pending[i] sets on the 3rd SI_ClkIn rising edge after irq_src[i] goes high and stays set until cleared.
REQ-017 Level mode (EDGE_SEL[i]=0): pending[i] equals the synced level; W1C has no effect on it.
REQ-018 Writing PENDING clears edge-mode bits whose wdata bit is 1; on simultaneous W1C and new edge, the edge wins and the bit stays set.
REQ-019 Writes to ENABLE and EDGE_SEL take effect on the next clock edge; writes to STATUS are ignored.
REQ-020 reg_rdata updates one cycle after reg_addr is presented; STATUS = {4'b0, irq_active, irq_req, state[1:0]}.
REQ-021 FSM states: IDLE=0, REQ=1, SERVICE=2.
REQ-022 IDLE: if (pending & ENABLE) is nonzero, latch the lowest set index into irq_id and go to REQ; irq_req rises one cycle after the qualifying pending bit.
REQ-023 REQ: irq_req=1 and irq_id holds; on irq_ack go to SERVICE and clear pending[irq_id] if it is edge-mode.
REQ-024 REQ withdraw: if pending[irq_id]&ENABLE[irq_id] drops to 0 before irq_ack, return to IDLE and deassert irq_req next cycle.
REQ-025 SERVICE: irq_req=0, irq_active=1; on irq_eoi go to IDLE.
REQ-026 Priority is re-evaluated only in IDLE; a higher-priority arrival during REQ does not change irq_id. There is no nesting.
REQ-027 irq_ack outside REQ and irq_eoi outside SERVICE are ignored.
REQ-028 Simultaneous irq_ack and new edge on the same source: the ack clears the old event and the new edge sets pending again.
REQ-029 irq_ack and irq_eoi in the same cycle while in REQ: go to SERVICE only; the eoi is dropped.

Reset
REQ-030 Asserting SI_Reset_N low, at any time including mid-handshake, forces state IDLE, irq_req=0, irq_active=0, irq_id=0, reg_rdata=0.
REQ-031 Reset also clears ENABLE=0, EDGE_SEL=all ones, pending=0 and all synchronizer flops.
REQ-032 After reset release, no request is raised until ENABLE is written.

Structure
REQ-033 Register addresses, FSM state encodings and STATUS bit positions live in a shared package, irq_pkg.
REQ-034 The per-bit synchronizer plus edge detector is a sub-module, irq_sync_edge, instantiated N_SRC times.

Verification
REQ-035 Reset, ENABLE=0x0F, pulse irq_src[2] for 1 cycle -> pending=0x04 after 3 edges, irq_req=1 and irq_id=2 one cycle later.
REQ-036 irq_src=0x0A simultaneously with ENABLE=0xFF -> irq_id=1; after ack+eoi, irq_id=3 is requested; PENDING reads 0x00 after both acks.
REQ-037 In REQ for id 5, write PENDING=0x20 before ack -> irq_req drops next cycle and state returns to IDLE.
REQ-038 EDGE_SEL[0]=0, irq_src[0] held high, ack then eoi -> re-requested immediately; W1C of bit 0 has no effect.
REQ-039 Drop SI_Reset_N while in SERVICE -> all outputs 0 asynchronously; ENABLE reads 0x00 after release.
REQ-040 Drive irq_ack in IDLE and irq_eoi in REQ -> no state change, irq_req unchanged.
